seq_mul_digit: RTL and testbench
================================

# seq_mul_digit

Parametrised, digit-serial integer multiplier for the FP32 FPU datapath, replacing the fixed 8×8 combinational tree where area matters more than latency. It consumes DIGIT_BITS bits of the multiplier operand per cycle and produces a full 2·WIDTH-bit product, with optional signed operation. Valid/ready handshakes on both sides let it sit between the FPU operand stage and the normaliser. The default configuration (WIDTH = 24) serves mantissa products.

## Interface
- WIDTH, 24: operand width in bits; legal range 2..32.
- DIGIT_BITS, 4: multiplier bits retired per cycle; legal range 1..WIDTH.
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  operand pair presented.
- o_ready  out  1  block can accept operands.
- i_a  in  WIDTH  multiplicand.
- i_b  in  WIDTH  multiplier.
- i_signed  in  1  treat i_a/i_b as two's complement; sampled with operands.
- i_kill  in  1  abort current operation.
- o_valid  out  1  product available.
- i_ready  in  1  consumer accepts product.
- o_product  out  2·WIDTH  result.

## Operation
- NDIG = ceil(WIDTH/DIGIT_BITS). i_b is zero-extended to NDIG·DIGIT_BITS bits for digit slicing.
- States:
  - IDLE: o_ready = 1. On i_valid, capture operands, load the accumulator with 0 and the digit counter with 0, then go to BUSY.
  - BUSY: each cycle, accumulator += (|a| × digit[k]) << (k·DIGIT_BITS), and k increments. After the step with k = NDIG−1, go to DONE.
  - DONE: o_valid = 1 and o_product holds the final value. On i_ready, go to IDLE.
- Signed mode:
  - At capture, operands are converted to magnitude.
  - neg = sign(a) XOR sign(b) is stored.
  - On the BUSY→DONE transition, the product is two's-complement negated if neg.
  - Magnitude of −2^(WIDTH−1) is held in WIDTH bits unsigned, so the product is exact.
- Unsigned mode: no conversion; the product is exact in 2·WIDTH bits. No overflow is possible in either mode.
- i_kill:
  - In BUSY or DONE: the next state is IDLE and o_valid drops. The product is discarded.
  - In IDLE: i_kill has priority over i_valid, so nothing is captured.
- Operands are registered at capture. i_a, i_b and i_signed may change freely afterwards.
- o_product is stable and unchanged while o_valid = 1 and i_ready = 0.
- Reset, including mid-operation:
  - State returns to IDLE.
  - o_ready = 1, o_valid = 0, o_product = 0.
  - Accumulator, counter and sign flag are cleared.

## Timing
- Acceptance happens on the edge where o_ready & i_valid & !i_kill.
- o_valid asserts exactly NDIG cycles after the acceptance edge.
  - Defaults (NDIG = 6): 6 cycles.
  - WIDTH = 8, DIGIT_BITS = 4: 2 cycles.
- Product handoff happens on the edge where o_valid & i_ready. o_ready is 1 in the following cycle.
- No overlap: o_ready is low throughout BUSY and DONE. Minimum initiation interval is NDIG + 2 cycles when i_ready is held high.
- o_ready and o_valid are decoded directly from registered state, with no combinational input-to-output paths.

## Configuration
- SEQ_MUL_SIGNED_EN defined: signed mode operates as described above.
- SEQ_MUL_SIGNED_EN undefined:
  - i_signed is ignored and all operands are unsigned.
  - Magnitude conversion, the sign flag and the final negation are removed from the RTL.
  - Port list and timing are unchanged.

## Test plan
- Max unsigned product, WIDTH = 8, DIGIT_BITS = 4, i_signed = 0: a = 0xFF, b = 0xFF → o_product = 0xFE01, o_valid 2 cycles after accept.
- Defaults, mantissa corner: a = 0xFFFFFF, b = 0xFFFFFF, unsigned → 0xFFFFFE000001 after 6 cycles. a = 0x800000, b = 0x800000 → 0x400000000000.
- Signed corners, WIDTH = 8, SEQ_MUL_SIGNED_EN defined:
  - −128 × −128 → 0x4000.
  - −1 × 1 → 0xFFFF.
  - −3 × 5 → 0xFFF1.
  - Same −1 × 1 vectors with the macro undefined → 0x00FF.
- Back-pressure: hold i_ready = 0 for 5 cycles in DONE → o_product stable, o_ready = 0, new i_valid ignored. Releasing i_ready completes the handoff, and o_ready = 1 in the next cycle.
- Abort and reset:
  - i_kill in the 2nd BUSY cycle → IDLE next cycle, o_valid never asserts.
  - i_rst asserted mid-BUSY → immediate IDLE with o_product = 0.
  - A following 7 × 9 (WIDTH = 8) returns 0x003F.
- Non-dividing digit, WIDTH = 10, DIGIT_BITS = 4 (NDIG = 3): a = 0x3FF, b = 0x3FF → 0xFF801 after 3 cycles.

Source files
------------

// File: rtl/seq_mul_digit.sv
// seq_mul_digit: digit-serial integer multiplier with valid/ready handshakes.
// Each cycle it retires DIGIT_BITS bits of the multiplier and produces a
// 2*WIDTH-bit product.
// Optional signed mode is compiled in when SEQ_MUL_SIGNED_EN is defined.
// Without that macro, i_signed is ignored and all operands are unsigned.
//
// state  | meaning
// S_IDLE | waiting for an operand pair, o_ready = 1
// S_BUSY | one multiplier digit retired per cycle, counter k selects the shift
// S_DONE | product held on o_product with o_valid = 1 until i_ready or i_kill
module seq_mul_digit #(
  parameter int WIDTH      = 24,
  parameter int DIGIT_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_signed,
  input  logic                 i_kill,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int NDIG = (WIDTH + DIGIT_BITS - 1) / DIGIT_BITS;
  localparam int BW   = NDIG * DIGIT_BITS;        // zero-extended multiplier width
  localparam int PPW  = WIDTH + DIGIT_BITS;       // one partial product
  localparam int PW2  = WIDTH + BW;               // partial product after largest shift
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   a_q;
  logic [BW-1:0]      b_q;
  logic [2*WIDTH-1:0] acc;
  logic [KW-1:0]      k;

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [PPW-1:0]     pp;
  logic [PW2-1:0]     pp_sh;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] acc_final;

  assign accept = i_valid && !i_kill;
  assign last   = (k == KW'(NDIG - 1));

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q;
  logic neg_nx;

  // Magnitude of the most negative value still fits in WIDTH bits unsigned,
  // so the magnitude product is always exact.
  assign a_abs     = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign b_abs     = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign neg_nx    = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
  assign acc_final = neg_q ? -acc_sum : acc_sum;

  // Sign flag captured with the operands, consumed on the final step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      neg_q <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      neg_q <= neg_nx;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = i_signed;
  assign a_abs         = i_a;
  assign b_abs         = i_b;
  assign acc_final     = acc_sum;
`endif

  // Current digit times the multiplicand, aligned by the digit index.
  assign pp      = PPW'(a_q) * PPW'(b_q[DIGIT_BITS-1:0]);
  assign pp_sh   = PW2'(pp) << (int'(k) * DIGIT_BITS);
  assign acc_sum = acc + pp_sh[2*WIDTH-1:0];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; kill wins over everything, including a new operand.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_BUSY;
      S_BUSY: begin
        if (i_kill)    state_nx = S_IDLE;
        else if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        if (i_kill || i_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, digit stepping and accumulation; a kill discards the product.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      k   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q <= a_abs;
            b_q <= BW'(b_abs);
            acc <= '0;
            k   <= '0;
          end
        end
        S_BUSY: begin
          if (i_kill) begin
            acc <= '0;
          end else begin
            acc <= last ? acc_final : acc_sum;
            b_q <= b_q >> DIGIT_BITS;
            k   <= k + KW'(1);
          end
        end
        S_DONE: begin
          if (i_kill) acc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (state == S_IDLE);
  assign o_valid   = (state == S_DONE);
  assign o_product = acc;

endmodule

// File: tb/tb_seq_mul_digit.sv
// Directed bench for seq_mul_digit: three instances (8/4, 10/4, 24/4) share
// the control inputs; each has its own i_valid so only one runs at a time.
module tb_seq_mul_digit;

  logic        clk = 1'b0;
  logic        rst;
  logic        kill;
  logic        ready;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        v8, v10, v24;

  logic        r8, r10, r24;
  logic        ov8, ov10, ov24;
  logic [15:0] p8;
  logic [19:0] p10;
  logic [47:0] p24;

  int          sel;
  logic        or_s;
  logic        ov_s;
  logic [63:0] p_s;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEQ_MUL_SIGNED_EN
  localparam logic [63:0] EXP_M128 = 64'h4000;
  localparam logic [63:0] EXP_M1X1 = 64'hFFFF;
  localparam logic [63:0] EXP_M3X5 = 64'hFFF1;
`else
  localparam logic [63:0] EXP_M128 = 64'h4000;
  localparam logic [63:0] EXP_M1X1 = 64'h00FF;
  localparam logic [63:0] EXP_M3X5 = 64'h04F1;
`endif

  always #5 clk = ~clk;

  seq_mul_digit #(.WIDTH(8), .DIGIT_BITS(4)) u_w8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(r8),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_signed(sgn), .i_kill(kill),
    .o_valid(ov8), .i_ready(ready), .o_product(p8)
  );

  seq_mul_digit #(.WIDTH(10), .DIGIT_BITS(4)) u_w10 (
    .i_clk(clk), .i_rst(rst), .i_valid(v10), .o_ready(r10),
    .i_a(a[9:0]), .i_b(b[9:0]), .i_signed(sgn), .i_kill(kill),
    .o_valid(ov10), .i_ready(ready), .o_product(p10)
  );

  seq_mul_digit u_w24 (
    .i_clk(clk), .i_rst(rst), .i_valid(v24), .o_ready(r24),
    .i_a(a[23:0]), .i_b(b[23:0]), .i_signed(sgn), .i_kill(kill),
    .o_valid(ov24), .i_ready(ready), .o_product(p24)
  );

  // Route the selected instance to common observation signals.
  always_comb begin
    or_s = r8;
    ov_s = ov8;
    p_s  = {48'd0, p8};
    case (sel)
      1: begin or_s = r10; ov_s = ov10; p_s = {44'd0, p10}; end
      2: begin or_s = r24; ov_s = ov24; p_s = {16'd0, p24}; end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    v8  = (sel == 0) ? v : 1'b0;
    v10 = (sel == 1) ? v : 1'b0;
    v24 = (sel == 2) ? v : 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ov_s && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One full transaction: accept, check latency and product, hand off.
  task automatic mul_run(input int s, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tsgn, input logic [63:0] exp, input int lat,
                         input string tag);
    int n;
    sel = s;
    a = ta; b = tb; sgn = tsgn;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    a = ~ta; b = ~tb; sgn = ~tsgn;
    check_eq({tag, "_busy_rdy"}, {63'd0, or_s}, 64'd0);
    wait_valid(n);
    check_eq({tag, "_lat"}, 64'(n), 64'(lat));
    check_eq({tag, "_prod"}, p_s, exp);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check_eq({tag, "_rdy_after"}, {63'd0, or_s}, 64'd1);
  endtask

  initial begin
    int  n;
    logic seen;
    rst = 1'b1; kill = 1'b0; ready = 1'b0; sgn = 1'b0;
    a = '0; b = '0; sel = 0;
    v8 = 1'b0; v10 = 1'b0; v24 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_eq("reset_rdy", {63'd0, or_s}, 64'd1);
      check_eq("reset_vld", {63'd0, ov_s}, 64'd0);
      check_eq("reset_prod", p_s, 64'd0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    mul_run(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 2, "w8_ffxff");
    mul_run(2, 32'hFFFFFF, 32'hFFFFFF, 1'b0, 64'hFFFFFE000001, 6, "w24_max");
    mul_run(2, 32'h800000, 32'h800000, 1'b0, 64'h400000000000, 6, "w24_msb");
    mul_run(0, 32'h80, 32'h80, 1'b1, EXP_M128, 2, "w8_m128sq");
    mul_run(0, 32'hFF, 32'h01, 1'b1, EXP_M1X1, 2, "w8_m1x1");
    mul_run(0, 32'hFD, 32'h05, 1'b1, EXP_M3X5, 2, "w8_m3x5");
    mul_run(0, 32'hFF, 32'h01, 1'b0, 64'h00FF, 2, "w8_u255x1");
    mul_run(1, 32'h3FF, 32'h3FF, 1'b0, 64'hFF801, 3, "w10_max");

    // Back-pressure: product held, new operands ignored while in DONE.
    sel = 0; a = 32'd3; b = 32'd4; sgn = 1'b0;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    wait_valid(n);
    check_eq("bp_lat", 64'(n), 64'd2);
    a = 32'd5; b = 32'd5;
    set_valid(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_prod", p_s, 64'h000C);
      check_eq("bp_rdy", {63'd0, or_s}, 64'd0);
      check_eq("bp_vld", {63'd0, ov_s}, 64'd1);
    end
    set_valid(1'b0);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check_eq("bp_rdy_after", {63'd0, or_s}, 64'd1);
    check_eq("bp_vld_after", {63'd0, ov_s}, 64'd0);
    @(posedge clk); #1;
    check_eq("bp_no_capture", {63'd0, or_s}, 64'd1);

    // Kill in the second BUSY cycle.
    sel = 2; a = 32'hFFFFFF; b = 32'hFFFFFF;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq("kill_rdy", {63'd0, or_s}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov_s) seen = 1'b1;
    end
    check_eq("kill_no_vld", {63'd0, seen}, 64'd0);

    // Kill beats valid in IDLE.
    sel = 0; a = 32'd2; b = 32'd2;
    set_valid(1'b1);
    kill = 1'b1;
    @(posedge clk); #1;
    set_valid(1'b0);
    kill = 1'b0;
    check_eq("kill_idle_rdy", {63'd0, or_s}, 64'd1);

    // Asynchronous reset mid-BUSY.
    sel = 0; a = 32'hFF; b = 32'hFF;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    check_eq("rstb_busy", {63'd0, or_s}, 64'd0);
    rst = 1'b1;
    #1;
    check_eq("rstb_rdy", {63'd0, or_s}, 64'd1);
    check_eq("rstb_vld", {63'd0, ov_s}, 64'd0);
    check_eq("rstb_prod", p_s, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mul_run(0, 32'd7, 32'd9, 1'b0, 64'h003F, 2, "w8_7x9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
